dcache_drain_ctrl: RTL

DCACHE_DRAIN_CTRL -- requirements
Module: dcache_drain_ctrl

---
 rtl/dcache_drain_ctrl_pkg.sv | 24 ++
 rtl/dcache_drain_ctrl_if.sv | 29 ++
 rtl/dcache_line_merge.sv | 21 ++
 rtl/dcache_drain_ctrl.sv | 132 +++++++++++++
 4 files changed

// File: rtl/dcache_drain_ctrl_pkg.sv
// Shared widths, entry layout and FSM encoding for the
// D-cache store-buffer drain controller.
package dcache_drain_ctrl_pkg;

  localparam int DC_ADDR_W = 32;
  localparam int DC_DATA_W = 32;
  localparam int DC_LINE_W = 128;
  localparam int SB_ENTRY_W = DC_ADDR_W + DC_DATA_W;
  localparam int DRAIN_CNT_W = 16;

  typedef struct packed {
    logic [DC_ADDR_W-1:0] addr;
    logic [DC_DATA_W-1:0] data;
  } sb_entry_t;

  typedef enum logic [2:0] {
    IDLE,
    LOOKUP,
    WRITE,
    MREQ,
    FILL
  } state_t;

endpackage

// File: rtl/dcache_drain_ctrl_if.sv
// Store-buffer and memory-side handshakes of the drain controller.
// master = controller side, slave = store buffer / memory side.
interface dcache_drain_ctrl_if
  import dcache_drain_ctrl_pkg::*;
#(
  parameter int ADDR_W = DC_ADDR_W,
  parameter int DATA_W = DC_DATA_W,
  parameter int LINE_W = DC_LINE_W
) ();

  logic                     sb_valid;
  logic [ADDR_W+DATA_W-1:0] sb_entry;
  logic                     sb_ready;
  logic                     mem_req;
  logic [ADDR_W-1:0]        mem_addr;
  logic                     mem_ack;
  logic [LINE_W-1:0]        mem_line;

  modport master (
    input  sb_valid, sb_entry, mem_ack, mem_line,
    output sb_ready, mem_req, mem_addr
  );

  modport slave (
    output sb_valid, sb_entry, mem_ack, mem_line,
    input  sb_ready, mem_req, mem_addr
  );

endinterface

// File: rtl/dcache_line_merge.sv
// Inserts one data word into a cache line at a word index.
// Word 0 sits in the line LSBs.
module dcache_line_merge
  import dcache_drain_ctrl_pkg::*;
#(
  parameter int DATA_W = DC_DATA_W,
  parameter int LINE_W = DC_LINE_W,
  parameter int IDX_W  = $clog2(LINE_W / DATA_W)
) (
  input  logic [LINE_W-1:0] line,
  input  logic [DATA_W-1:0] data,
  input  logic [IDX_W-1:0]  idx,
  output logic [LINE_W-1:0] merged
);

  always_comb begin
    merged = line;
    merged[int'(idx) * DATA_W +: DATA_W] = data;
  end

endmodule

// File: rtl/dcache_drain_ctrl.sv
// Drains store-buffer entries into the D-cache: write on hit,
// line fetch + merged fill on miss; loads always win the port.
module dcache_drain_ctrl
  import dcache_drain_ctrl_pkg::*;
#(
  parameter int ADDR_W = DC_ADDR_W,
  parameter int DATA_W = DC_DATA_W,
  parameter int LINE_W = DC_LINE_W
) (
  input  logic                   clk,
  input  logic                   reset,
  dcache_drain_ctrl_if.master    bus,
  input  logic                   load_req,
  input  logic                   tag_hit,
  output logic [ADDR_W-1:0]      cache_addr,
  output logic                   cache_we,
  output logic [DATA_W-1:0]      cache_wdata,
  output logic                   cache_fill,
  output logic [LINE_W-1:0]      fill_line,
  output logic                   busy,
  output logic [DRAIN_CNT_W-1:0] drained
);

  localparam int OFF_W  = $clog2(LINE_W / 8);
  localparam int BYTE_W = $clog2(DATA_W / 8);
  localparam int IDX_W  = OFF_W - BYTE_W;

  state_t state_q, state_d;

  // addr_q doubles as the cache_addr bus register
  logic [ADDR_W-1:0]      addr_q;
  logic [DATA_W-1:0]      data_q;
  logic [DATA_W-1:0]      wdata_q;
  logic [LINE_W-1:0]      fill_q;
  logic [ADDR_W-1:0]      maddr_q;
  logic [DRAIN_CNT_W-1:0] drained_q;
  logic [LINE_W-1:0]      merged;
  logic [ADDR_W-1:0]      line_addr;

  logic sb_ready, mem_req, we, fill, accept;

  assign accept    = sb_ready & bus.sb_valid;
  assign line_addr = {addr_q[ADDR_W-1:OFF_W], {OFF_W{1'b0}}};

  dcache_line_merge #(
    .DATA_W (DATA_W),
    .LINE_W (LINE_W),
    .IDX_W  (IDX_W)
  ) u_merge (
    .line   (bus.mem_line),
    .data   (data_q),
    .idx    (addr_q[OFF_W-1:BYTE_W]),
    .merged (merged)
  );

  always_ff @(posedge clk) begin
    if (reset) state_q <= IDLE;
    else       state_q <= state_d;
  end

  always_comb begin
    state_d  = state_q;
    sb_ready = 1'b0;
    mem_req  = 1'b0;
    we       = 1'b0;
    fill     = 1'b0;
    unique case (state_q)
      IDLE: begin
        sb_ready = 1'b1;
        if (bus.sb_valid) state_d = LOOKUP;
      end
      LOOKUP: begin
        if (!load_req) state_d = tag_hit ? WRITE : MREQ;
      end
      WRITE: begin
        if (!load_req) begin
          we      = 1'b1;
          state_d = IDLE;
        end
      end
      MREQ: begin
        mem_req = 1'b1;
        if (bus.mem_ack) state_d = FILL;
      end
      FILL: begin
        if (!load_req) begin
          fill    = 1'b1;
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      addr_q    <= '0;
      data_q    <= '0;
      wdata_q   <= '0;
      fill_q    <= '0;
      maddr_q   <= '0;
      drained_q <= '0;
    end else begin
      if (accept) begin
        addr_q <= bus.sb_entry[ADDR_W+DATA_W-1 -: ADDR_W];
        data_q <= bus.sb_entry[DATA_W-1:0];
      end
      if (state_q == LOOKUP && !load_req) begin
        if (tag_hit) wdata_q <= data_q;
        else         maddr_q <= line_addr;
      end
      // merge uses the word index before addr_q becomes the line address
      if (state_q == MREQ && bus.mem_ack) begin
        fill_q <= merged;
        addr_q <= line_addr;
      end
      if (we || fill) drained_q <= drained_q + 16'd1;
    end
  end

  assign bus.sb_ready = sb_ready;
  assign bus.mem_req  = mem_req;
  assign bus.mem_addr = maddr_q;
  assign cache_addr   = addr_q;
  assign cache_we     = we;
  assign cache_wdata  = wdata_q;
  assign cache_fill   = fill;
  assign fill_line    = fill_q;
  assign busy         = (state_q != IDLE);
  assign drained      = drained_q;

endmodule
